iot_event_arbiter: RTL and testbench
====================================

// Module: iot_event_arbiter
// PURPOSE
//  Serialises connect/disconnect requests from N_DEV IoT device ports into single-cycle
//  change/on_off strobes for the active-device counter. At most one event reaches the
//  counter per strobe. Arbitration between device ports is round-robin.
//  Tracks per-device active state, so the counter cannot be double-incremented or
//  double-decremented. Redundant requests are granted but rejected with no strobe.
// PARAMETERS
//  N_DEV    4   number of device request ports (2..16)
//  PTR_W    2   width of round-robin pointer, = clog2(N_DEV)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       reset, synchronous, active-high
//  req          in   N_DEV   req[i]=1: device i requests a state change; held until gnt[i]
//  req_on       in   N_DEV   req_on[i]=1 connect, 0 disconnect; stable while req[i]=1
//  gnt          out  N_DEV   one-hot, 1-cycle grant pulse to the serviced device
//  reject       out  1       1-cycle pulse with gnt: request was redundant, no counter event
//  change       out  1       1-cycle strobe to counter: apply one event
//  on_off       out  1       direction with change: 1 = count up, 0 = count down
//  active_mask  out  N_DEV   active_mask[i]=1 while device i is connected
//  busy         out  1       1 while FSM is in GRANT state
// BEHAVIOUR
//  Reset: gnt=0, reject=0, change=0, on_off=0, active_mask=0, busy=0, ptr=0, state=IDLE.
//  Reset mid-operation discards any in-flight grant. Requesters must re-request.
//  All outputs are registered.
//  FSM:
//   IDLE:
//    - If any req bit is set, select winner w = first set req bit scanning
//      ptr, ptr+1, ..., ptr+N_DEV-1 (mod N_DEV).
//    - On that edge: gnt[w]<=1, ptr<=(w+1) mod N_DEV, state<=GRANT.
//    - Redundant request (req_on[w]==active_mask[w]): reject<=1, change<=0.
//    - Valid request: change<=1, on_off<=req_on[w], active_mask[w]<=req_on[w].
//    - No req bit set: outputs stay 0, ptr unchanged.
//   GRANT (1 cycle):
//    - gnt/change/reject/on_off visible. No arbitration; req is ignored.
//    - Next edge: gnt, change, reject, on_off <= 0; state<=IDLE.
//  Latency: req sampled in IDLE at edge k; gnt/change high during cycle k+1.
//  Throughput: at most one grant per 2 cycles.
//  Handshake: device i deasserts req[i] in the cycle after gnt[i]=1.
//   If req[i] is still high then, it counts as a new request.
//  Fairness: a continuously requesting device waits at most N_DEV grants.
//  on_off is 0 whenever change=0. gnt is never multi-hot.
//  Simultaneous requests from the same device in both directions are impossible
//   (one req_on bit per device).
//  Counter wrap-around is the counter's concern. This block bounds
//   active devices to N_DEV via active_mask.
// TESTING (N_DEV=4)
//  T1 reset:
//   - rst=1 for 2 cycles, random req.
//   - Expect: all outputs 0, no gnt.
//   - After release with req=0: stays idle.
//  T2 single connect:
//   - req=0001, req_on=0001 at edge k.
//   - Expect cycle k+1: gnt=0001, change=1, on_off=1, active_mask=0001.
//   - Expect cycle k+2: all strobes 0.
//  T3 round-robin:
//   - req=1111, req_on=1111 held; each granted device drops its req.
//   - Expect: grants in order 0001,0010,0100,1000, 2 cycles apart.
//   - Expect: 4 change strobes; active_mask=1111.
//  T4 redundant:
//   - Device 2 already active; req[2]=1, req_on[2]=1.
//   - Expect: gnt=0100, reject=1, change=0, active_mask unchanged.
//  T5 disconnect + pointer:
//   - ptr=3; req=1001, req_on=0000, devices 0 and 3 active.
//   - Expect: gnt=1000 first, then 0001.
//   - Expect: two change strobes with on_off=0; active_mask bits 0 and 3 cleared.
//  T6 reset mid-grant:
//   - rst=1 in the GRANT cycle.
//   - Expect next cycle: all outputs 0, active_mask=0, ptr=0.

Source files
------------

// File: rtl/iot_event_arbiter_if.sv
// Purpose: request/grant bundle between N_DEV IoT device ports and the event arbiter.
// Latency: none, wires only.
// Backpressure: a device holds req until it sees its gnt pulse.
// Ports (signals):
//   req, req_on           device -> arbiter: change request and direction (1 connect, 0 disconnect)
//   gnt, reject           arbiter -> device: one-hot grant pulse and redundant-request flag
//   change, on_off        arbiter -> counter: single-cycle event strobe and its direction
//   active_mask, busy     arbiter status: connected devices, grant cycle in progress
interface iot_event_arbiter_if #(
  parameter int N_DEV = 4
);
  logic [N_DEV-1:0] req;
  logic [N_DEV-1:0] req_on;
  logic [N_DEV-1:0] gnt;
  logic             reject;
  logic             change;
  logic             on_off;
  logic [N_DEV-1:0] active_mask;
  logic             busy;

  // Device / counter side.
  modport master (
    output req, req_on,
    input  gnt, reject, change, on_off, active_mask, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_on,
    output gnt, reject, change, on_off, active_mask, busy
  );
endinterface

// File: rtl/iot_event_arbiter.sv
// Purpose: round-robin serialiser of device connect/disconnect requests into counter strobes.
// Latency: req sampled at edge k, gnt/change/reject visible for cycle k+1; one grant per 2 cycles.
// Backpressure: requests wait (held by the device) while another grant is in flight.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        slave side of iot_event_arbiter_if (req/req_on in; gnt, reject, change,
//              on_off, active_mask, busy out - all registered)
module iot_event_arbiter #(
  parameter int N_DEV = 4,
  parameter int PTR_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  iot_event_arbiter_if.slave      bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [N_DEV-1:0]   gnt_q, gnt_nxt;
  logic               reject_q, reject_nxt;
  logic               change_q, change_nxt;
  logic               on_off_q, on_off_nxt;
  logic [N_DEV-1:0]   mask_q, mask_nxt;

  // Round-robin winner search, starting at ptr and wrapping at N_DEV
  // (N_DEV need not be a power of two, so wrap explicitly).
  logic               found;
  logic [PTR_W-1:0]   win;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_DEV; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_DEV) idx = idx - N_DEV;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    mask_nxt   = mask_q;
    // Strobes are single-cycle: they drop unless a new grant is issued this edge.
    gnt_nxt    = '0;
    reject_nxt = 1'b0;
    change_nxt = 1'b0;
    on_off_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt[win] = 1'b1;
          ptr_nxt      = (win == PTR_W'(N_DEV - 1)) ? '0 : win + 1'b1;
          state_nxt    = GRANT;
          // Request matching current state would double-count: grant but suppress the event.
          if (bus.req_on[win] == mask_q[win]) begin
            reject_nxt = 1'b1;
          end else begin
            change_nxt    = 1'b1;
            on_off_nxt    = bus.req_on[win];
            mask_nxt[win] = bus.req_on[win];
          end
        end
      end
      GRANT: begin
        // Requests are ignored here; the granted device drops req during this cycle.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_q    <= '0;
      reject_q <= 1'b0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      mask_q   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_q    <= gnt_nxt;
      reject_q <= reject_nxt;
      change_q <= change_nxt;
      on_off_q <= on_off_nxt;
      mask_q   <= mask_nxt;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.reject      = reject_q;
  assign bus.change      = change_q;
  assign bus.on_off      = on_off_q;
  assign bus.active_mask = mask_q;
  assign bus.busy        = (state == GRANT);

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Purpose: directed checks of the event arbiter with N_DEV=4.
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: the bench drops each granted req during the grant cycle.
module tb_iot_event_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iot_event_arbiter_if #(.N_DEV(4)) bus ();

  iot_event_arbiter #(.N_DEV(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] gnt, input logic reject,
                           input logic change, input logic on_off, input logic [3:0] mask,
                           input logic busy);
    check({tag, ".gnt"},    32'(bus.gnt),         32'(gnt));
    check({tag, ".reject"}, 32'(bus.reject),      32'(reject));
    check({tag, ".change"}, 32'(bus.change),      32'(change));
    check({tag, ".on_off"}, 32'(bus.on_off),      32'(on_off));
    check({tag, ".mask"},   32'(bus.active_mask), 32'(mask));
    check({tag, ".busy"},   32'(bus.busy),        32'(busy));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.req    = 4'($urandom);
    bus.req_on = 4'($urandom);

    // T1: reset held two cycles with random requests.
    step();
    bus.req    = 4'($urandom);
    bus.req_on = 4'($urandom);
    step();
    check_all("t1_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    rst     = 1'b0;
    bus.req = 4'b0000;
    step();
    step();
    check_all("t1_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // T2: single connect of device 0.
    bus.req    = 4'b0001;
    bus.req_on = 4'b0001;
    step();
    check_all("t2_grant", 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
    bus.req = 4'b0000;
    step();
    check_all("t2_after", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);

    // Reset to bring ptr back to 0 and clear the mask before the rotation test.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t3_pre_mask", 32'(bus.active_mask), 32'h0);

    // T3: all four connect; grants rotate 0,1,2,3 two cycles apart.
    bus.req    = 4'b1111;
    bus.req_on = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_gnt;
      logic [3:0] exp_mask;
      exp_gnt  = 4'(1 << i);
      exp_mask = 4'((1 << (i + 1)) - 1);
      step();
      check_all($sformatf("t3_grant%0d", i), exp_gnt, 1'b0, 1'b1, 1'b1, exp_mask, 1'b1);
      bus.req[i] = 1'b0;
      step();
      check_all($sformatf("t3_gap%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0, exp_mask, 1'b0);
    end
    check("t3_mask", 32'(bus.active_mask), 32'hF);

    // T4: redundant connect from already-active device 2 (ptr is 0).
    bus.req    = 4'b0100;
    bus.req_on = 4'b0100;
    step();
    check_all("t4_grant", 4'b0100, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
    bus.req = 4'b0000;
    step();
    check_all("t4_after", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);

    // T5: ptr is 3; devices 3 and 0 disconnect, device 3 must win first.
    bus.req    = 4'b1001;
    bus.req_on = 4'b0000;
    step();
    check_all("t5_grant3", 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b1);
    bus.req[3] = 1'b0;
    step();
    check_all("t5_gap", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0);
    step();
    check_all("t5_grant0", 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b1);
    bus.req[0] = 1'b0;
    step();
    check_all("t5_after", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);

    // T6: reset asserted during the grant cycle (ptr is 1, device 1 disconnects).
    bus.req    = 4'b0010;
    bus.req_on = 4'b0000;
    step();
    check_all("t6_grant", 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1);
    rst     = 1'b1;
    bus.req = 4'b0000;
    step();
    check_all("t6_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    // With ptr back at 0, device 1 beats device 3 (a stale ptr of 2 would pick 3).
    bus.req    = 4'b1010;
    bus.req_on = 4'b1010;
    step();
    check_all("t6_ptr", 4'b0010, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1);
    bus.req[1] = 1'b0;
    step();
    step();
    check_all("t6_next", 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b1);
    bus.req = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
